// File: rtl/param_pkg.sv
// Shared data-bus parameters and AXI4 encodings for the DBIU.
// Provides DBUS_AW/DBUS_DW/DBUS_ISEL, AXI response/burst codes and a size helper.
package param_pkg;

  localparam int DBUS_AW   = 32;
  localparam int DBUS_DW   = 32;
  localparam int DBUS_ISEL = DBUS_DW / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // AXI size code for a full-width beat: log2 of bytes per beat.
  function automatic logic [2:0] axi_size(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/dbiu_axi_bridge.sv
// DBIU: CPU req/ack data port to single-beat AXI4 master, one transaction in flight.
// Ports: clk, rst_n (sync, active low); CPU req/adr/dat/we/sel in, dat/ack out;
// AXI4 AW/W/B/AR/R channels; err_dbiu2m only when DBIU_RESP_ERR_EN is defined.
module dbiu_axi_bridge
  import param_pkg::*;
#(
  parameter int AXI_ID_W = 4,
  parameter int AXI_ID   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 req_m2dbiu,
  input  logic [DBUS_AW-1:0]   adr_m2dbiu,
  input  logic [DBUS_DW-1:0]   dat_m2dbiu,
  input  logic                 we_m2dbiu,
  input  logic [DBUS_ISEL-1:0] sel_m2dbiu,
  output logic [DBUS_DW-1:0]   dat_dbiu2m,
  output logic                 ack_dbiu2m,
`ifdef DBIU_RESP_ERR_EN
  output logic                 err_dbiu2m,
`endif

  output logic [AXI_ID_W-1:0]  axi_awid,
  output logic [DBUS_AW-1:0]   axi_awaddr,
  output logic [7:0]           axi_awlen,
  output logic [2:0]           axi_awsize,
  output logic [1:0]           axi_awburst,
  output logic                 axi_awvalid,
  input  logic                 axi_awready,

  output logic [DBUS_DW-1:0]   axi_wdata,
  output logic [DBUS_ISEL-1:0] axi_wstrb,
  output logic                 axi_wlast,
  output logic                 axi_wvalid,
  input  logic                 axi_wready,

  input  logic [AXI_ID_W-1:0]  axi_bid,
  input  logic [1:0]           axi_bresp,
  input  logic                 axi_bvalid,
  output logic                 axi_bready,

  output logic [AXI_ID_W-1:0]  axi_arid,
  output logic [DBUS_AW-1:0]   axi_araddr,
  output logic [7:0]           axi_arlen,
  output logic [2:0]           axi_arsize,
  output logic [1:0]           axi_arburst,
  output logic                 axi_arvalid,
  input  logic                 axi_arready,

  input  logic [AXI_ID_W-1:0]  axi_rid,
  input  logic [DBUS_DW-1:0]   axi_rdata,
  input  logic [1:0]           axi_rresp,
  input  logic                 axi_rlast,
  input  logic                 axi_rvalid,
  output logic                 axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    ACK
  } state_t;

  state_t state, state_n;

  logic                 awvalid_n, wvalid_n, bready_n;
  logic                 arvalid_n, rready_n, ack_n;
  logic [DBUS_AW-1:0]   awaddr_n, araddr_n;
  logic [DBUS_DW-1:0]   wdata_n, dat_n;
  logic [DBUS_ISEL-1:0] wstrb_n;
  logic                 aw_done, w_done;
`ifdef DBIU_RESP_ERR_EN
  logic                 err_n;
`endif

  // Single-beat INCR bursts with a fixed ID.
  assign axi_awid    = AXI_ID_W'(AXI_ID);
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = axi_size(DBUS_DW);
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_wlast   = 1'b1;
  assign axi_arid    = AXI_ID_W'(AXI_ID);
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = axi_size(DBUS_DW);
  assign axi_arburst = AXI_BURST_INCR;

  // A channel counts as done once its valid has dropped
  // or its handshake happens this cycle.
  assign aw_done = !axi_awvalid || axi_awready;
  assign w_done  = !axi_wvalid  || axi_wready;

  logic unused_in;
  assign unused_in = ^{axi_bid, axi_rid, axi_rlast,
                       axi_bresp, axi_rresp};

  always_comb begin
    state_n   = state;
    awvalid_n = axi_awvalid;
    wvalid_n  = axi_wvalid;
    bready_n  = axi_bready;
    arvalid_n = axi_arvalid;
    rready_n  = axi_rready;
    ack_n     = 1'b0;
    awaddr_n  = axi_awaddr;
    araddr_n  = axi_araddr;
    wdata_n   = axi_wdata;
    wstrb_n   = axi_wstrb;
    dat_n     = dat_dbiu2m;
`ifdef DBIU_RESP_ERR_EN
    err_n     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (req_m2dbiu) begin
          if (we_m2dbiu) begin
            state_n   = WR_AW_W;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            awaddr_n  = adr_m2dbiu;
            wdata_n   = dat_m2dbiu;
            wstrb_n   = sel_m2dbiu;
          end else begin
            state_n   = RD_AR;
            arvalid_n = 1'b1;
            araddr_n  = adr_m2dbiu;
          end
        end
      end
      WR_AW_W: begin
        if (axi_awvalid && axi_awready)
          awvalid_n = 1'b0;
        if (axi_wvalid && axi_wready)
          wvalid_n = 1'b0;
        if (aw_done && w_done) begin
          state_n  = WR_B;
          bready_n = 1'b1;
        end
      end
      WR_B: begin
        if (axi_bvalid && axi_bready) begin
          state_n  = ACK;
          bready_n = 1'b0;
          ack_n    = 1'b1;
`ifdef DBIU_RESP_ERR_EN
          err_n    = axi_bresp[1];
`endif
        end
      end
      RD_AR: begin
        if (axi_arvalid && axi_arready) begin
          state_n   = RD_R;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end
      end
      RD_R: begin
        if (axi_rvalid && axi_rready) begin
          state_n  = ACK;
          rready_n = 1'b0;
          ack_n    = 1'b1;
          dat_n    = axi_rdata;
`ifdef DBIU_RESP_ERR_EN
          err_n    = axi_rresp[1];
`endif
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      ack_dbiu2m  <= 1'b0;
      axi_awaddr  <= '0;
      axi_araddr  <= '0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      dat_dbiu2m  <= '0;
`ifdef DBIU_RESP_ERR_EN
      err_dbiu2m  <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      axi_awvalid <= awvalid_n;
      axi_wvalid  <= wvalid_n;
      axi_bready  <= bready_n;
      axi_arvalid <= arvalid_n;
      axi_rready  <= rready_n;
      ack_dbiu2m  <= ack_n;
      axi_awaddr  <= awaddr_n;
      axi_araddr  <= araddr_n;
      axi_wdata   <= wdata_n;
      axi_wstrb   <= wstrb_n;
      dat_dbiu2m  <= dat_n;
`ifdef DBIU_RESP_ERR_EN
      err_dbiu2m  <= err_n;
`endif
    end
  end

endmodule
